iagu_add_sched: RTL and testbench
=================================

# iagu_add_sched

Job-level scheduler for the input-buffer add-path address generator (IAGU add). It accepts one add job per valid/ready handshake and latches that job's geometry onto the generator's configuration inputs. It then fires one start pulse per tile, tracks the generator's read-enable to detect tile completion, and reports job completion or error. It sits between the NPU layer controller and the add-path AGU.

## Interface
Parameters:
- `TILE_W`, default 8: width of the tile count and tile index.
- `WDOG_CYC`, default 8: watchdog limit in cycles. Used only when `IAGU_SCHED_WDOG_EN` is defined.

Ports:
- `i_clk` input, 1: clock.
- `i_rst_n` input, 1: reset, asynchronous assert, active-low.
- `i_Job_Valid` input, 1: job request.
- `o_Job_Ready` output, 1: scheduler can accept a job. High only in IDLE.
- `i_Job_PieceNum` input, 8: input pieces per tile.
- `i_Job_YLength` input, 8: output Y length.
- `i_Job_XLength` input, 8: output X length.
- `i_Job_TileNum` input, TILE_W: number of tiles in the job.
- `o_AGU_Start` output, 1: one-cycle start pulse to the AGU.
- `o_Input_PieceNum` output, 8: latched piece count, driven to the AGU.
- `o_Out_YLength` output, 8: latched Y length, driven to the AGU.
- `o_Out_XLength` output, 8: latched X length, driven to the AGU.
- `i_AGU_Busy` input, 1: AGU read-enable, fed back from the AGU.
- `o_Busy` output, 1: high in any state other than IDLE.
- `o_TileIdx` output, TILE_W: index of the tile currently running, 0-based.
- `o_Done` output, 1: one-cycle pulse at the end of the job.
- `o_Err` output, 1: one-cycle pulse on a rejected or aborted job.

## Operation
States: IDLE, START, WAIT, RUN, DONE.

- **IDLE**
  - `o_Job_Ready` = 1.
  - On `i_Job_Valid`, latch all four job fields and clear `o_TileIdx`.
  - If any field is zero: pulse `o_Err` next cycle and stay in IDLE. No start pulse is issued. Zero lengths would make the AGU counters wrap through 256.
  - Otherwise go to START.
- **START**
  - Drive `o_AGU_Start` = 1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - On `i_AGU_Busy` = 1, go to RUN.
- **RUN**
  - On `i_AGU_Busy` = 0 (tile finished):
    - If `o_TileIdx` + 1 == tile count, go to DONE.
    - Otherwise increment `o_TileIdx` and go to START.
- **DONE**
  - `o_Done` = 1 for this one cycle.
  - Go to IDLE.

Rules:
- Config outputs hold their latched values from acceptance until the next acceptance. They stay stable for the whole job.
- `o_AGU_Start` is never asserted outside START.
- `i_Job_Valid` is ignored while `o_Job_Ready` = 0.
- All counter arithmetic is unsigned. The tile compare is done at TILE_W+1 bits, so TileNum = 2^TILE_W − 1 works without wrap.

## Timing
- Reset values:
  - State = IDLE.
  - `o_Job_Ready` = 1.
  - `o_AGU_Start`, `o_Busy`, `o_Done`, `o_Err` = 0.
  - `o_TileIdx` = 0.
  - All config outputs = 0.
- Job accepted at clock edge T: `o_AGU_Start` is high during cycle T+1. Config outputs are valid from T+1.
- With the AGU attached, `i_AGU_Busy` rises at T+2 and stays high for P·X·Y cycles. RUN therefore sees busy low at T+2+P·X·Y.
- The next tile's start pulse falls in the cycle after busy is first seen low. The dead gap between tiles is 2 cycles of busy low.
- `o_Done` is high in the cycle after the last tile's busy is first seen low.
- `o_Err` for a zero-field job is high at T+1. `o_Job_Ready` stays 1 throughout.
- Asserting reset mid-job returns to IDLE immediately and clears all outputs. No `o_Done` or `o_Err` is produced for the aborted job.
- A busy glitch in WAIT shorter than one cycle is not filtered; busy is treated as a synchronous level.

## Configuration
`IAGU_SCHED_WDOG_EN`:
- **Defined:** a counter runs in WAIT. If `i_AGU_Busy` does not rise within `WDOG_CYC` cycles of entering WAIT:
  - pulse `o_Err`,
  - go to IDLE,
  - leave `o_TileIdx` at the failing tile.

  The counter clears on every entry to WAIT.
- **Undefined:** there is no counter. WAIT waits indefinitely. `o_Err` is driven only by zero-field rejection.

## Test plan
- **Single tile.** P=2, Y=3, X=4, Tiles=1, with the real AGU attached → one start pulse at T+1, busy for 24 cycles, `o_Done` at T+27, `o_Busy` then falls.
- **Multiple tiles.** P=1, Y=1, X=2, Tiles=3 → three start pulses spaced 4 cycles apart. `o_TileIdx` steps 0, 1, 2. `o_Done` comes exactly once.
- **Zero field.** Job with X=0 → `o_Err` at T+1, no start pulse, `o_Job_Ready` stays 1, and the next valid job runs normally.
- **Back-to-back request.** `i_Job_Valid` held high during a running job → the request is not accepted until IDLE. The second job's config appears only after the first job's `o_Done`.
- **Reset mid-job.** Deassert `i_rst_n` during RUN of tile 1 → all outputs at reset values immediately, no `o_Done`.
- **Watchdog.** With `IAGU_SCHED_WDOG_EN` defined and busy held at 0 → `o_Err` at WAIT entry + 8 cycles, state returns to IDLE.

Source files
------------

// File: rtl/iagu_add_sched.sv
// ---------------------------------------------------------------------------
// iagu_add_sched
//
// Job-level scheduler for the input-buffer add-path address generator.
// One add job is accepted per valid/ready handshake. Its geometry is latched
// onto the AGU configuration outputs. The scheduler then issues one start
// pulse per tile and follows the AGU read-enable to detect the end of each
// tile. It finishes the job with a one-cycle done pulse, or rejects the job
// with a one-cycle error pulse.
//
// Optional feature macro: IAGU_SCHED_WDOG_EN
//   When it is defined, a watchdog runs in WAIT. If the AGU does not raise
//   busy within WDOG_CYC cycles, the job is aborted with an error pulse.
//
// Ports
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_Job_Valid         job request
//   o_Job_Ready         scheduler can accept a job (high only in IDLE)
//   i_Job_PieceNum      input pieces per tile
//   i_Job_YLength       output Y length
//   i_Job_XLength       output X length
//   i_Job_TileNum       number of tiles in the job
//   o_AGU_Start         one-cycle start pulse per tile
//   o_Input_PieceNum    latched piece count, driven to the AGU
//   o_Out_YLength       latched Y length, driven to the AGU
//   o_Out_XLength       latched X length, driven to the AGU
//   i_AGU_Busy          AGU read-enable, treated as a synchronous level
//   o_Busy              high in any state other than IDLE
//   o_TileIdx           0-based index of the running tile
//   o_Done              one-cycle pulse at the end of the job
//   o_Err               one-cycle pulse on a rejected or aborted job
// ---------------------------------------------------------------------------
module iagu_add_sched #(
    parameter int TILE_W   = 8,
    parameter int WDOG_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_Job_Valid,
    output logic              o_Job_Ready,
    input  logic [7:0]        i_Job_PieceNum,
    input  logic [7:0]        i_Job_YLength,
    input  logic [7:0]        i_Job_XLength,
    input  logic [TILE_W-1:0] i_Job_TileNum,
    output logic              o_AGU_Start,
    output logic [7:0]        o_Input_PieceNum,
    output logic [7:0]        o_Out_YLength,
    output logic [7:0]        o_Out_XLength,
    input  logic              i_AGU_Busy,
    output logic              o_Busy,
    output logic [TILE_W-1:0] o_TileIdx,
    output logic              o_Done,
    output logic              o_Err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [TILE_W:0] TILE_ONE = (TILE_W+1)'(1);

    logic [2:0]        state_q,    state_d;
    logic [7:0]        piece_q,    piece_d;
    logic [7:0]        ylen_q,     ylen_d;
    logic [7:0]        xlen_q,     xlen_d;
    logic [TILE_W-1:0] tile_num_q, tile_num_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic              err_q,      err_d;

    logic              job_zero;
    logic              last_tile;

`ifdef IAGU_SCHED_WDOG_EN
    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    // A zero length would make the AGU counters wrap through 256, and a
    // zero tile count makes no sense. Either case rejects the job.
    assign job_zero = (i_Job_PieceNum == 8'd0) || (i_Job_YLength == 8'd0) ||
                      (i_Job_XLength == 8'd0)  || (i_Job_TileNum == '0);

    // The compare is one bit wider than the tile index, so a tile count of
    // 2^TILE_W-1 ends correctly instead of wrapping.
    assign last_tile = (({1'b0, tile_idx_q} + TILE_ONE) == {1'b0, tile_num_q});

    always_comb begin
        // NOTE: every _d gets a default before the case statement, so a branch
        // that does not assign it simply holds the flop and no latch is inferred.
        state_d    = state_q;
        piece_d    = piece_q;
        ylen_d     = ylen_q;
        xlen_d     = xlen_q;
        tile_num_d = tile_num_q;
        tile_idx_d = tile_idx_q;
        err_d      = 1'b0;
`ifdef IAGU_SCHED_WDOG_EN
        wdog_d     = wdog_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_Job_Valid) begin
                    // A rejected job latches its fields too. The config
                    // outputs always show the most recently accepted request.
                    piece_d    = i_Job_PieceNum;
                    ylen_d     = i_Job_YLength;
                    xlen_d     = i_Job_XLength;
                    tile_num_d = i_Job_TileNum;
                    tile_idx_d = '0;
                    if (job_zero) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef IAGU_SCHED_WDOG_EN
                // START is the only way into WAIT, so clearing here resets
                // the watchdog on every WAIT entry.
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (i_AGU_Busy) begin
                    state_d = S_RUN;
`ifdef IAGU_SCHED_WDOG_EN
                end else if (wdog_q == WD_LIMIT) begin
                    // The tile index is left at the tile that failed.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (!i_AGU_Busy) begin
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        tile_idx_d = tile_idx_q + 1'b1;
                        state_d    = S_START;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            piece_q    <= 8'd0;
            ylen_q     <= 8'd0;
            xlen_q     <= 8'd0;
            tile_num_q <= '0;
            tile_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            piece_q    <= piece_d;
            ylen_q     <= ylen_d;
            xlen_q     <= xlen_d;
            tile_num_q <= tile_num_d;
            tile_idx_q <= tile_idx_d;
            err_q      <= err_d;
        end
    end

`ifdef IAGU_SCHED_WDOG_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign o_Job_Ready      = (state_q == S_IDLE);
    assign o_AGU_Start      = (state_q == S_START);
    assign o_Busy           = (state_q != S_IDLE);
    assign o_Done           = (state_q == S_DONE);
    assign o_Err            = err_q;
    assign o_TileIdx        = tile_idx_q;
    assign o_Input_PieceNum = piece_q;
    assign o_Out_YLength    = ylen_q;
    assign o_Out_XLength    = xlen_q;

endmodule

// File: tb/tb_iagu_add_sched.sv
// ---------------------------------------------------------------------------
// tb_iagu_add_sched
//
// Self-checking bench for iagu_add_sched. A small behavioural AGU drives busy
// for P*X*Y cycles after each start pulse. A negedge monitor logs every
// start, done and error event together with its cycle number and the config
// seen at that moment. For every job, the expected event times are derived
// arithmetically from the acceptance cycle c:
//   tile k start pulse at c + 1 + k*(P*X*Y + 2)
//   done pulse         at c + 1 + N*(P*X*Y + 2)
//   zero-field error   at c + 1
// When IAGU_SCHED_WDOG_EN is defined, a watchdog case is also exercised.
// ---------------------------------------------------------------------------
module tb_iagu_add_sched;

    logic       clk;
    logic       rst_n;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_p, job_y, job_x, job_n;
    logic       agu_start;
    logic [7:0] cfg_p, cfg_y, cfg_x;
    logic       agu_busy;
    logic       busy;
    logic [7:0] tile_idx;
    logic       done;
    logic       err;

    iagu_add_sched #(.TILE_W(8), .WDOG_CYC(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_Job_Valid      (job_valid),
        .o_Job_Ready      (job_ready),
        .i_Job_PieceNum   (job_p),
        .i_Job_YLength    (job_y),
        .i_Job_XLength    (job_x),
        .i_Job_TileNum    (job_n),
        .o_AGU_Start      (agu_start),
        .o_Input_PieceNum (cfg_p),
        .o_Out_YLength    (cfg_y),
        .o_Out_XLength    (cfg_x),
        .i_AGU_Busy       (agu_busy),
        .o_Busy           (busy),
        .o_TileIdx        (tile_idx),
        .o_Done           (done),
        .o_Err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: the value held during a cycle is its index.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AGU: busy high for P*X*Y cycles, starting the cycle after
    // the start pulse. agu_en = 0 models a dead AGU.
    bit agu_en = 1'b1;
    int agu_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) agu_rem <= 0;
        else if (agu_start && agu_en) agu_rem <= int'(cfg_p) * int'(cfg_x) * int'(cfg_y);
        else if (agu_rem != 0) agu_rem <= agu_rem - 1;
    end
    assign agu_busy = (agu_rem != 0);

    // Event log
    typedef struct {
        int kind;   // 0 start, 1 done, 2 err
        int cyc;
        int idx;
        int p;
        int y;
        int x;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (agu_start) evq.push_back('{0, cyc, int'(tile_idx), int'(cfg_p), int'(cfg_y), int'(cfg_x)});
            if (done)      evq.push_back('{1, cyc, int'(tile_idx), int'(cfg_p), int'(cfg_y), int'(cfg_x)});
            if (err)       evq.push_back('{2, cyc, int'(tile_idx), int'(cfg_p), int'(cfg_y), int'(cfg_x)});
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Present a job at a negedge once ready is high. Returns the acceptance
    // cycle. When hold is set, valid is left asserted.
    task automatic drive_job(input int p, input int y, input int x, input int n,
                             input bit hold, output int c);
        int guard = 0;
        @(negedge clk);
        while (!job_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_job", job_ready, 1);
        job_p     = 8'(p);
        job_y     = 8'(y);
        job_x     = 8'(x);
        job_n     = 8'(n);
        job_valid = 1'b1;
        c         = cyc;
        @(negedge clk);
        if (!hold) job_valid = 1'b0;
    endtask

    // Compare the logged events of one job against the arithmetic schedule.
    task automatic verify(input int c, input int p, input int y, input int x, input int n);
        bit zero = (p == 0) || (y == 0) || (x == 0) || (n == 0);
        int per  = p * y * x + 2;
        int hi   = zero ? c + 1 : c + 1 + n * per;
        int k    = 0;
        int nd   = 0;
        int ne   = 0;
        foreach (evq[i]) begin
            if (evq[i].cyc >= c + 1 && evq[i].cyc <= hi) begin
                case (evq[i].kind)
                    0: begin
                        check("start_cycle", evq[i].cyc, c + 1 + k * per);
                        check("start_tile_idx", evq[i].idx, k);
                        check("start_cfg_p", evq[i].p, p);
                        check("start_cfg_y", evq[i].y, y);
                        check("start_cfg_x", evq[i].x, x);
                        k++;
                    end
                    1: begin
                        nd++;
                        check("done_cycle", evq[i].cyc, hi);
                        check("done_tile_idx", evq[i].idx, n - 1);
                        check("done_cfg_x", evq[i].x, x);
                    end
                    default: begin
                        ne++;
                        check("err_cycle", evq[i].cyc, c + 1);
                    end
                endcase
            end
        end
        check("start_count", k, zero ? 0 : n);
        check("done_count", nd, zero ? 0 : 1);
        check("err_count", ne, zero ? 1 : 0);
    endtask

    // Run a complete job and verify it.
    task automatic run_job(input int p, input int y, input int x, input int n);
        int  c;
        bit  zero = (p == 0) || (y == 0) || (x == 0) || (n == 0);
        int  hi   = zero ? 0 : n * (p * y * x + 2);
        drive_job(p, y, x, n, 1'b0, c);
        // drive_job returns in cycle c+1.
        if (zero) begin
            check("zero_ready_held", job_ready, 1);
            check("zero_no_busy", busy, 0);
            check("zero_cfg_x_latched", cfg_x, x);
            check("zero_cfg_p_latched", cfg_p, p);
        end
        wait_until(c + 2 + hi);
        check("idle_busy_low", busy, 0);
        check("idle_ready_high", job_ready, 1);
        verify(c, p, y, x, n);
    endtask

    initial begin
        int c;
        int ca;
        int cb;
        int nd;
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_p     = 8'd0;
        job_y     = 8'd0;
        job_x     = 8'd0;
        job_n     = 8'd0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready", job_ready, 1);
        check("rst_start", agu_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tile_idx", tile_idx, 0);
        check("rst_cfg_p", cfg_p, 0);
        check("rst_cfg_y", cfg_y, 0);
        check("rst_cfg_x", cfg_x, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile: done at T+27
        run_job(2, 3, 4, 1);
        // Multiple tiles: starts 4 cycles apart
        run_job(1, 1, 2, 3);
        // Zero field rejected, next job runs normally
        run_job(1, 1, 0, 1);
        run_job(3, 1, 1, 2);
        // Largest tile count at TILE_W = 8
        run_job(1, 1, 1, 255);

        // Back-to-back: valid held high, second job accepted only in IDLE
        drive_job(1, 1, 2, 2, 1'b1, ca);
        job_p = 8'd2;
        job_y = 8'd1;
        job_x = 8'd1;
        job_n = 8'd1;
        cb    = ca + 1 + 2 * 4 + 1;
        wait_until(cb + 1);
        job_valid = 1'b0;
        wait_until(cb + 1 + 4 + 1);
        verify(ca, 1, 1, 2, 2);
        verify(cb, 2, 1, 1, 1);

        // Reset during RUN of tile 1
        drive_job(1, 1, 2, 3, 1'b0, c);
        wait_until(c + 7);
        check("pre_rst_tile_idx", tile_idx, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", job_ready, 1);
        check("mid_rst_start", agu_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_tile_idx", tile_idx, 0);
        check("mid_rst_cfg_x", cfg_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(c + 40);
        nd = 0;
        foreach (evq[i]) if (evq[i].kind != 0 && evq[i].cyc > c) nd++;
        check("rst_no_done_or_err", nd, 0);

        // Randomized jobs, some carrying a zero field
        for (int j = 0; j < 12; j++) begin
            int p = $urandom_range(1, 4);
            int y = $urandom_range(1, 4);
            int x = $urandom_range(1, 4);
            int n = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: p = 0;
                    1: y = 0;
                    2: x = 0;
                    default: n = 0;
                endcase
            end
            run_job(p, y, x, n);
        end

`ifdef IAGU_SCHED_WDOG_EN
        // Dead AGU: the error fires 8 cycles after WAIT entry (c+2)
        agu_en = 1'b0;
        drive_job(1, 1, 1, 1, 1'b0, c);
        wait_until(c + 12);
        check("wdog_busy_low", busy, 0);
        check("wdog_tile_idx", tile_idx, 0);
        nd = 0;
        foreach (evq[i]) begin
            if (evq[i].cyc > c && evq[i].kind == 2) begin
                nd++;
                check("wdog_err_cycle", evq[i].cyc, c + 10);
            end
            if (evq[i].cyc > c && evq[i].kind == 1) check("wdog_no_done", 1, 0);
        end
        check("wdog_err_count", nd, 1);
        agu_en = 1'b1;
        run_job(1, 2, 1, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
